// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution loader and engine.
package conv_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_X    = 3'd1,
    ST_LOAD_Y    = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_DONE = 3'd4
  } loader_state_e;

  // A job size is legal when it names at least one word and fits the memory.
  function automatic logic size_legal(input logic [31:0] size, input logic [31:0] depth);
    return (size != 32'd0) && (size <= depth);
  endfunction

endpackage

// File: rtl/mem_wr_port.sv
// Registered memory write port: one write cycle per accepted beat.
module mem_wr_port #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              accept_i,
  input  logic [ADDR_W-1:0] cnt_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o
);

  always_ff @(posedge clk) begin
    if (reset) begin
      we_o    <= 1'b0;
      addr_o  <= '0;
      wdata_o <= '0;
    end else begin
      we_o <= accept_i;
      if (accept_i) begin
        addr_o  <= cnt_i;
        wdata_o <= data_i;
      end
    end
  end

endmodule

// File: rtl/conv_mem_loader.sv
// Loads X then Y sample streams into two memories, then starts the conv engine.
module conv_mem_loader
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  input  logic [ADDR_W:0]   cfg_size_x,
  input  logic [ADDR_W:0]   cfg_size_y,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_x_we,
  output logic [ADDR_W-1:0] mem_x_addr,
  output logic [DATA_W-1:0] mem_x_wdata,
  output logic              mem_y_we,
  output logic [ADDR_W-1:0] mem_y_addr,
  output logic [DATA_W-1:0] mem_y_wdata,
  output logic              conv_start,
  output logic [ADDR_W:0]   conv_size_x,
  output logic [ADDR_W:0]   conv_size_y,
  input  logic              conv_done,
  output logic              busy,
  output logic              err_size
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  loader_state_e   state_q;
  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] size_x_q;
  logic [ADDR_W:0] size_y_q;
  logic            start_q;
  logic            err_q;

  logic accept;
  logic accept_x;
  logic accept_y;
  logic cnt_last_x;
  logic cnt_last_y;
  logic cfg_ok;

  // Handshake: a beat moves when s_valid && s_ready; s_ready depends only on state_q.
  assign s_ready    = (state_q == ST_LOAD_X) || (state_q == ST_LOAD_Y);
  assign accept     = s_valid && s_ready;
  assign accept_x   = accept && (state_q == ST_LOAD_X);
  assign accept_y   = accept && (state_q == ST_LOAD_Y);
  assign cnt_last_x = (cnt_q + CNT_ONE) == size_x_q;
  assign cnt_last_y = (cnt_q + CNT_ONE) == size_y_q;
  assign cfg_ok     = size_legal(32'(cfg_size_x), 32'(DEPTH)) &&
                      size_legal(32'(cfg_size_y), 32'(DEPTH));

  assign busy        = (state_q != ST_IDLE);
  assign conv_start  = start_q;
  assign err_size    = err_q;
  assign conv_size_x = size_x_q;
  assign conv_size_y = size_y_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      size_x_q <= '0;
      size_y_q <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_valid) begin
            if (cfg_ok) begin
              size_x_q <= cfg_size_x;
              size_y_q <= cfg_size_y;
              cnt_q    <= '0;
              state_q  <= ST_LOAD_X;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_LOAD_X: begin
          if (accept) begin
            if (cnt_last_x) begin
              cnt_q   <= '0;
              state_q <= ST_LOAD_Y;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        ST_LOAD_Y: begin
          if (accept) begin
            if (cnt_last_y) begin
              // Start pulse lands in the same cycle as the final memY write.
              cnt_q   <= '0;
              start_q <= 1'b1;
              state_q <= ST_START;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        ST_START: state_q <= ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (conv_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mem_wr_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_x (
    .clk     (clk),
    .reset   (reset),
    .accept_i(accept_x),
    .cnt_i   (cnt_q[ADDR_W-1:0]),
    .data_i  (s_data),
    .we_o    (mem_x_we),
    .addr_o  (mem_x_addr),
    .wdata_o (mem_x_wdata)
  );

  mem_wr_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_y (
    .clk     (clk),
    .reset   (reset),
    .accept_i(accept_y),
    .cnt_i   (cnt_q[ADDR_W-1:0]),
    .data_i  (s_data),
    .we_o    (mem_y_we),
    .addr_o  (mem_y_addr),
    .wdata_o (mem_y_wdata)
  );

endmodule

// File: tb/tb_conv_mem_loader.sv
// Directed bench for conv_mem_loader: write logging plus per-scenario checks.
module tb_conv_mem_loader;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int WR_W   = ADDR_W + DATA_W;

  logic              clk;
  logic              reset;
  logic              cfg_valid;
  logic [ADDR_W:0]   cfg_size_x;
  logic [ADDR_W:0]   cfg_size_y;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              mem_x_we;
  logic [ADDR_W-1:0] mem_x_addr;
  logic [DATA_W-1:0] mem_x_wdata;
  logic              mem_y_we;
  logic [ADDR_W-1:0] mem_y_addr;
  logic [DATA_W-1:0] mem_y_wdata;
  logic              conv_start;
  logic [ADDR_W:0]   conv_size_x;
  logic [ADDR_W:0]   conv_size_y;
  logic              conv_done;
  logic              busy;
  logic              err_size;

  int n_checks;
  int n_fail;
  int cyc;
  int err_cnt;
  int both_we_cnt;

  logic [WR_W-1:0] wx_q[$];
  logic [WR_W-1:0] wy_q[$];
  int              wx_cyc_q[$];
  int              wy_cyc_q[$];
  int              start_cyc_q[$];

  conv_mem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_size_x (cfg_size_x),
    .cfg_size_y (cfg_size_y),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .mem_x_we   (mem_x_we),
    .mem_x_addr (mem_x_addr),
    .mem_x_wdata(mem_x_wdata),
    .mem_y_we   (mem_y_we),
    .mem_y_addr (mem_y_addr),
    .mem_y_wdata(mem_y_wdata),
    .conv_start (conv_start),
    .conv_size_x(conv_size_x),
    .conv_size_y(conv_size_y),
    .conv_done  (conv_done),
    .busy       (busy),
    .err_size   (err_size)
  );

  // Clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Log every write, start pulse and error pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_x_we) begin
      wx_q.push_back({mem_x_addr, mem_x_wdata});
      wx_cyc_q.push_back(cyc);
    end
    if (mem_y_we) begin
      wy_q.push_back({mem_y_addr, mem_y_wdata});
      wy_cyc_q.push_back(cyc);
    end
    if (mem_x_we && mem_y_we) both_we_cnt++;
    if (conv_start) start_cyc_q.push_back(cyc);
    if (err_size) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1, "timeout");
  end

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wx_q.delete(); wy_q.delete();
    wx_cyc_q.delete(); wy_cyc_q.delete(); start_cyc_q.delete();
    err_cnt = 0;
    both_we_cnt = 0;
  endtask

  task automatic send_cfg(input int sx, input int sy);
    cfg_valid  = 1'b1;
    cfg_size_x = (ADDR_W + 1)'(sx);
    cfg_size_y = (ADDR_W + 1)'(sy);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic offer_beat(input logic [DATA_W-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL beat_ready: s_ready=%b required 1 when offering %0h", s_ready, d);
    end
    tick();
  endtask

  task automatic finish_job();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_idle: busy=%b required 0", busy);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if ({s_ready, busy, mem_x_we, mem_y_we, conv_start, err_size} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 000000",
               {s_ready, busy, mem_x_we, mem_y_we, conv_start, err_size});
    end
    n_checks++;
    if ({mem_x_addr, mem_x_wdata, mem_y_addr, mem_y_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_ports: got %0h required 0",
               {mem_x_addr, mem_x_wdata, mem_y_addr, mem_y_wdata});
    end
    n_checks++;
    if ({conv_size_x, conv_size_y} !== '0) begin
      n_fail++;
      $display("FAIL reset_sizes: got %0h/%0h required 0/0", conv_size_x, conv_size_y);
    end
  endtask

  task automatic test_basic_load();
    logic [WR_W-1:0] exp_q[$];
    clear_logs();
    send_cfg(3, 2);
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_ready_latency: s_ready=%b required 1", s_ready);
    end
    offer_beat(8'd10); offer_beat(8'd11); offer_beat(8'd12);
    offer_beat(8'd20); offer_beat(8'd21);
    s_valid = 1'b0;
    n_checks++;
    if (conv_start !== 1'b1 || mem_y_we !== 1'b1) begin
      n_fail++;
      $display("FAIL start_with_last_write: start=%b y_we=%b required 1/1", conv_start, mem_y_we);
    end
    tick();
    n_checks++;
    if (conv_start !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_pulse_width: start=%b busy=%b required 0/1", conv_start, busy);
    end
    exp_q = '{{5'd0, 8'd10}, {5'd1, 8'd11}, {5'd2, 8'd12}};
    n_checks++;
    if (wx_q.size() != 3 || wx_q != exp_q) begin
      n_fail++;
      $display("FAIL basic_x_writes: got %p required %p", wx_q, exp_q);
    end
    exp_q = '{{5'd0, 8'd20}, {5'd1, 8'd21}};
    n_checks++;
    if (wy_q.size() != 2 || wy_q != exp_q) begin
      n_fail++;
      $display("FAIL basic_y_writes: got %p required %p", wy_q, exp_q);
    end
    n_checks++;
    if (wx_cyc_q.size() != 3 || wy_cyc_q.size() != 2 ||
        wx_cyc_q[1] != wx_cyc_q[0] + 1 || wx_cyc_q[2] != wx_cyc_q[0] + 2 ||
        wy_cyc_q[0] != wx_cyc_q[0] + 3 || wy_cyc_q[1] != wx_cyc_q[0] + 4) begin
      n_fail++;
      $display("FAIL basic_consecutive: x cycles %p y cycles %p required consecutive", wx_cyc_q, wy_cyc_q);
    end
    n_checks++;
    if (start_cyc_q.size() != 1 || wy_cyc_q.size() != 2 || start_cyc_q[0] != wy_cyc_q[1]) begin
      n_fail++;
      $display("FAIL basic_start_cycle: starts %p required one at %p[1]", start_cyc_q, wy_cyc_q);
    end
    n_checks++;
    if (conv_size_x !== 6'd3 || conv_size_y !== 6'd2) begin
      n_fail++;
      $display("FAIL basic_sizes: got %0d/%0d required 3/2", conv_size_x, conv_size_y);
    end
    tick(); tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_done_busy: busy=%b required 1", busy);
    end
    finish_job();
  endtask

  task automatic test_bad_cfg();
    clear_logs();
    s_valid = 1'b1;
    s_data  = 8'h77;
    send_cfg(0, 4);
    n_checks++;
    if (err_size !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL err_zero: err=%b busy=%b ready=%b required 1/0/0", err_size, busy, s_ready);
    end
    tick();
    n_checks++;
    if (err_size !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse_width: err=%b required 0", err_size);
    end
    send_cfg(33, 1);
    n_checks++;
    if (err_size !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL err_oversize: err=%b busy=%b ready=%b required 1/0/0", err_size, busy, s_ready);
    end
    tick();
    s_valid = 1'b0;
    n_checks++;
    if (err_cnt != 2) begin
      n_fail++;
      $display("FAIL err_count: got %0d required 2", err_cnt);
    end
    n_checks++;
    if (conv_size_x !== 6'd3 || conv_size_y !== 6'd2) begin
      n_fail++;
      $display("FAIL err_sizes_kept: got %0d/%0d required 3/2", conv_size_x, conv_size_y);
    end
    n_checks++;
    if (wx_q.size() != 0 || wy_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_no_consume: writes x=%0d y=%0d required 0/0", wx_q.size(), wy_q.size());
    end
  endtask

  task automatic test_full_depth();
    int bad_x;
    int bad_y;
    clear_logs();
    send_cfg(32, 32);
    for (int i = 0; i < 64; i++) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      offer_beat((i < 32) ? 8'(i * 7 + 3) : 8'(240 - (i - 32)));
    end
    s_valid = 1'b0;
    tick(); tick();
    bad_x = 0;
    bad_y = 0;
    if (wx_q.size() == 32 && wy_q.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        if (wx_q[i] !== {5'(i), 8'(i * 7 + 3)}) bad_x++;
        if (wy_q[i] !== {5'(i), 8'(240 - i)}) bad_y++;
      end
    end
    n_checks++;
    if (wx_q.size() + wy_q.size() != 64) begin
      n_fail++;
      $display("FAIL full_we_count: got %0d+%0d required 64", wx_q.size(), wy_q.size());
    end
    n_checks++;
    if (wx_q.size() != 32 || bad_x != 0) begin
      n_fail++;
      $display("FAIL full_x_contents: size %0d bad %0d required 32/0", wx_q.size(), bad_x);
    end
    n_checks++;
    if (wy_q.size() != 32 || bad_y != 0) begin
      n_fail++;
      $display("FAIL full_y_contents: size %0d bad %0d required 32/0", wy_q.size(), bad_y);
    end
    n_checks++;
    if (start_cyc_q.size() != 1 || both_we_cnt != 0) begin
      n_fail++;
      $display("FAIL full_start_overlap: starts %0d overlaps %0d required 1/0", start_cyc_q.size(), both_we_cnt);
    end
    n_checks++;
    if (conv_size_x !== 6'd32 || conv_size_y !== 6'd32) begin
      n_fail++;
      $display("FAIL full_sizes: got %0d/%0d required 32/32", conv_size_x, conv_size_y);
    end
    finish_job();
  endtask

  task automatic test_ignored_inputs();
    logic [WR_W-1:0] exp_q[$];
    clear_logs();
    send_cfg(2, 3);
    conv_done = 1'b1;
    offer_beat(8'hA1);
    conv_done = 1'b0;
    offer_beat(8'hA2);
    cfg_valid  = 1'b1;
    cfg_size_x = 6'd5;
    cfg_size_y = 6'd5;
    offer_beat(8'hB1);
    cfg_valid = 1'b0;
    offer_beat(8'hB2);
    offer_beat(8'hB3);
    s_valid = 1'b0;
    tick(); tick();
    exp_q = '{{5'd0, 8'hA1}, {5'd1, 8'hA2}};
    n_checks++;
    if (wx_q != exp_q) begin
      n_fail++;
      $display("FAIL ignore_x_writes: got %p required %p", wx_q, exp_q);
    end
    exp_q = '{{5'd0, 8'hB1}, {5'd1, 8'hB2}, {5'd2, 8'hB3}};
    n_checks++;
    if (wy_q != exp_q) begin
      n_fail++;
      $display("FAIL ignore_y_writes: got %p required %p", wy_q, exp_q);
    end
    n_checks++;
    if (conv_size_x !== 6'd2 || conv_size_y !== 6'd3 || err_cnt != 0) begin
      n_fail++;
      $display("FAIL ignore_cfg: sizes %0d/%0d errs %0d required 2/3/0", conv_size_x, conv_size_y, err_cnt);
    end
    n_checks++;
    if (start_cyc_q.size() != 1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_start: starts %0d busy %b required 1/1", start_cyc_q.size(), busy);
    end
    finish_job();
  endtask

  task automatic test_mid_reset();
    logic [WR_W-1:0] exp_q[$];
    clear_logs();
    send_cfg(3, 1);
    offer_beat(8'h01);
    offer_beat(8'h02);
    s_data = 8'h03;
    reset  = 1'b1;
    tick();
    reset   = 1'b0;
    s_valid = 1'b0;
    n_checks++;
    if ({s_ready, busy, mem_x_we, mem_y_we, conv_start, err_size} !== 6'b0 ||
        {conv_size_x, conv_size_y} !== '0 || {mem_x_addr, mem_x_wdata} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: flags %b sizes %0d/%0d x %0h required all 0",
               {s_ready, busy, mem_x_we, mem_y_we, conv_start, err_size},
               conv_size_x, conv_size_y, {mem_x_addr, mem_x_wdata});
    end
    tick();
    exp_q = '{{5'd0, 8'h01}, {5'd1, 8'h02}};
    n_checks++;
    if (wx_q != exp_q || wy_q.size() != 0 || start_cyc_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_reset_dropped: x %p y %0d starts %0d required %p/0/0",
               wx_q, wy_q.size(), start_cyc_q.size(), exp_q);
    end
    clear_logs();
    send_cfg(1, 1);
    offer_beat(8'h55);
    offer_beat(8'h66);
    s_valid = 1'b0;
    tick();
    n_checks++;
    if (wx_q.size() != 1 || wx_q[0] !== {5'd0, 8'h55} ||
        wy_q.size() != 1 || wy_q[0] !== {5'd0, 8'h66} || start_cyc_q.size() != 1) begin
      n_fail++;
      $display("FAIL post_reset_job: x %p y %p starts %0d required {0,55}/{0,66}/1",
               wx_q, wy_q, start_cyc_q.size());
    end
    finish_job();
  endtask

  task automatic test_back_to_back();
    clear_logs();
    send_cfg(2, 1);
    offer_beat(8'hC0); offer_beat(8'hC1); offer_beat(8'hC2);
    s_valid = 1'b0;
    tick();
    finish_job();
    clear_logs();
    send_cfg(1, 2);
    n_checks++;
    if (s_ready !== 1'b1 || conv_size_x !== 6'd1 || conv_size_y !== 6'd2) begin
      n_fail++;
      $display("FAIL b2b_accept: ready %b sizes %0d/%0d required 1/1/2", s_ready, conv_size_x, conv_size_y);
    end
    offer_beat(8'hD0); offer_beat(8'hD1); offer_beat(8'hD2);
    s_valid = 1'b0;
    tick();
    n_checks++;
    if (wx_q.size() != 1 || wx_q[0] !== {5'd0, 8'hD0} || wy_q.size() != 2 ||
        wy_q[0] !== {5'd0, 8'hD1} || wy_q[1] !== {5'd1, 8'hD2}) begin
      n_fail++;
      $display("FAIL b2b_addresses: x %p y %p required {0,D0} / {0,D1},{1,D2}", wx_q, wy_q);
    end
    finish_job();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    cfg_valid  = 1'b0;
    cfg_size_x = '0;
    cfg_size_y = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    conv_done  = 1'b0;
    clear_logs();
    test_reset();
    test_basic_load();
    test_bad_cfg();
    test_full_depth();
    test_ignored_inputs();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
